opb_simple_master: RTL

Single-beat OPB bus master: the initiator side of the OPB slave registers and BRAM bridges in our ROACH designs. Fabric logic submits one read or write request. The block arbitrates for the bus, drives the address and data phase, and handles slave retry, error and timeout. It returns read data or a completion status, so fabric-side test logic can exercise the software register map without the PPC.

---
 rtl/opb_simple_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/opb_simple_master.sv
// Single-beat OPB bus master: arbitrates, runs one transfer, and handles retry, errAck and timeout.
// Define OPB_SIMPLE_MASTER_BUSLOCK_EN to keep M_busLock asserted across retries.
module opb_simple_master #(
    parameter int C_TOUT_CYCLES = 16,
    parameter int C_MAX_RETRY   = 8
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        M_request,
    input  logic        OPB_MGrant,
    output logic        M_select,
    output logic        M_RNW,
    output logic [0:31] M_ABus,
    output logic [0:3]  M_BE,
    output logic [0:31] M_DBus,
    output logic        M_busLock,
    output logic        M_seqAddr,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_xferAck,
    input  logic        OPB_errAck,
    input  logic        OPB_retry,
    input  logic        OPB_toutSup,
    input  logic        OPB_timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [7:0] L_TOUT_LAST = 8'(C_TOUT_CYCLES - 1);
    localparam logic [7:0] L_MAX_RETRY = 8'(C_MAX_RETRY);

    logic [2:0]  r_state;
    logic        r_rnw;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [7:0]  r_retry_cnt;
    logic [7:0]  r_tout_cnt;

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_m_request;
    logic        r_m_select;
    logic        r_m_rnw;
    logic [0:31] r_m_abus;
    logic [0:3]  r_m_be;
    logic [0:31] r_m_dbus;
    logic        r_bus_lock;

    logic [2:0]  w_next_state;
    logic        w_rsp_err;
    logic        w_capture;
    logic        w_retry_inc;
    logic        w_tout_hit;
    logic        w_sel_next;

    // The counter hits its limit in the cycle it would step to C_TOUT_CYCLES.
    assign w_tout_hit = !OPB_toutSup && (r_tout_cnt == L_TOUT_LAST);
    assign w_sel_next = (w_next_state == S_XFER);

    // Next-state and completion decode; XFER exits follow ack > errAck > retry > timeout.
    always_comb begin
        w_next_state = r_state;
        w_rsp_err    = 1'b0;
        w_capture    = 1'b0;
        w_retry_inc  = 1'b0;
        case (r_state)
            S_IDLE:    w_next_state = req_valid ? S_REQ : S_IDLE;
            S_REQ:     w_next_state = OPB_MGrant ? S_XFER : S_REQ;
            S_XFER: begin
                if (OPB_xferAck) begin
                    w_next_state = S_RESP;
                    w_rsp_err    = OPB_errAck;
                    w_capture    = r_rnw & ~OPB_errAck;
                end else if (OPB_errAck) begin
                    w_next_state = S_RESP;
                    w_rsp_err    = 1'b1;
                end else if (OPB_retry) begin
                    if (r_retry_cnt == L_MAX_RETRY) begin
                        w_next_state = S_RESP;
                        w_rsp_err    = 1'b1;
                    end else begin
                        w_next_state = S_BACKOFF;
                        w_retry_inc  = 1'b1;
                    end
                end else if (OPB_timeout || w_tout_hit) begin
                    w_next_state = S_RESP;
                    w_rsp_err    = 1'b1;
                end else begin
                    w_next_state = S_XFER;
                end
            end
            S_BACKOFF: w_next_state = S_REQ;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State, latched request, counters and all bus/response outputs, registered from the next state.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state     <= S_IDLE;
            r_rnw       <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_retry_cnt <= 8'd0;
            r_tout_cnt  <= 8'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_m_request <= 1'b0;
            r_m_select  <= 1'b0;
            r_m_rnw     <= 1'b0;
            r_m_abus    <= 32'd0;
            r_m_be      <= 4'd0;
            r_m_dbus    <= 32'd0;
            r_bus_lock  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && req_valid) begin
                r_rnw   <= req_rnw;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (r_state == S_IDLE) begin
                r_retry_cnt <= 8'd0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 8'd1;
            end
            // Held at zero outside XFER, so every select phase starts a fresh count.
            if (r_state != S_XFER) begin
                r_tout_cnt <= 8'd0;
            end else if (!OPB_toutSup) begin
                r_tout_cnt <= r_tout_cnt + 8'd1;
            end
            r_req_ready <= (w_next_state == S_IDLE);
            r_m_request <= (w_next_state == S_REQ);
            r_m_select  <= w_sel_next;
            r_m_rnw     <= w_sel_next & r_rnw;
            r_m_abus    <= w_sel_next ? r_addr : 32'd0;
            r_m_be      <= w_sel_next ? r_be : 4'd0;
            r_m_dbus    <= (w_sel_next && !r_rnw) ? r_wdata : 32'd0;
            r_rsp_valid <= (w_next_state == S_RESP);
            r_rsp_err   <= w_rsp_err;
            r_rsp_rdata <= w_capture ? OPB_DBus : 32'd0;
`ifdef OPB_SIMPLE_MASTER_BUSLOCK_EN
            r_bus_lock  <= w_sel_next || (w_next_state == S_BACKOFF) ||
                           ((w_next_state == S_REQ) && r_bus_lock);
`else
            r_bus_lock  <= 1'b0;
`endif
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign M_request = r_m_request;
    assign M_select  = r_m_select;
    assign M_RNW     = r_m_rnw;
    assign M_ABus    = r_m_abus;
    assign M_BE      = r_m_be;
    assign M_DBus    = r_m_dbus;
    assign M_busLock = r_bus_lock;
    assign M_seqAddr = 1'b0;

endmodule
